// File: rtl/tdm_demux.sv
// Receive side of a WIDTH:1 time-division serial link: tracks the slot index,
// reassembles one WIDTH-bit word per frame and hands it out on a valid/ready port.
`timescale 1ns / 1ps

module tdm_demux #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [SEL_W-1:0] s,
  output logic             locked,
  output logic             sync_err,
  output logic             ovf,
  input  logic             err_clr
);

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(WIDTH - 1);

  logic [WIDTH-1:0] lane_q, lane_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             ovf_q, ovf_d;

  logic slot_zero, slot_last;
  logic acquire, resync, complete, accept;

  assign slot_zero = (s_q == '0);
  assign slot_last = (s_q == LastSlot);

  // acquire and resync both restart the frame with din as lane 0
  assign acquire  = din_valid && frame_start && !locked_q;
  assign resync   = din_valid && frame_start && locked_q && !slot_zero;
  assign complete = din_valid && locked_q && !resync && slot_last;
  assign accept   = o_valid_q && o_ready;

  always_comb begin
    lane_d   = lane_q;
    s_d      = s_q;
    locked_d = locked_q;

    if (acquire || resync) begin
      lane_d    = '0;
      lane_d[0] = din;
      s_d       = SEL_W'(1);
      locked_d  = 1'b1;
    end else if (complete) begin
      // final bit goes straight to o, so the lane register can start clean
      lane_d = '0;
      s_d    = '0;
    end else if (din_valid && locked_q) begin
      lane_d[s_q] = din;
      s_d         = s_q + SEL_W'(1);
    end
  end

  always_comb begin
    o_d       = o_q;
    o_valid_d = o_valid_q;
    if (complete) begin
      o_d       = {din, lane_q[WIDTH-2:0]};
      o_valid_d = 1'b1;
    end else if (accept) begin
      o_valid_d = 1'b0;
    end
  end

  // sticky flags: a new error on the same edge as err_clr still sets the flag
  always_comb begin
    sync_err_d = err_clr ? 1'b0 : sync_err_q;
    ovf_d      = err_clr ? 1'b0 : ovf_q;
    if (resync) begin
      sync_err_d = 1'b1;
    end
    if (complete && o_valid_q && !o_ready) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q     <= '0;
      s_q        <= '0;
      locked_q   <= 1'b0;
      o_q        <= '0;
      o_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      s_q        <= s_d;
      locked_q   <= locked_d;
      o_q        <= o_d;
      o_valid_q  <= o_valid_d;
      sync_err_q <= sync_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o        = o_q;
  assign o_valid  = o_valid_q;
  assign s        = s_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;
  assign ovf      = ovf_q;

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the 4:1 time-division link: a transmitter drives one lane per slot on a serial bit line, and this block reassembles a WIDTH-bit word.
- Tracks the slot index internally, locked by a frame_start marker on slot 0.
- Presents each completed word on a valid/ready output.
- Flags framing errors and overruns with sticky status bits.

Parameters:
- WIDTH, 4, number of lanes (slots) per frame; must be ≥ 2.
- SEL_W, 2, slot counter width; equals clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- din  input  1  serial lane bit for the current slot.
- din_valid  input  1  a beat occurs when this is high at a clk edge.
- frame_start  input  1  marks the current beat as slot 0; only meaningful when din_valid=1.
- o  output  WIDTH  reassembled word; bit k is the bit received in slot k.
- o_valid  output  1  o holds an unconsumed word.
- o_ready  input  1  consumer accepts o when o_valid and o_ready are both high at a clk edge.
- s  output  SEL_W  slot index expected on the next beat.
- locked  output  1  frame alignment acquired.
- sync_err  output  1  sticky: frame_start was seen at a non-zero slot.
- ovf  output  1  sticky: a word completed while the previous word was still pending.
- err_clr  input  1  clears sync_err and ovf.

Behaviour:
- Reset: rst_n=0 at an edge forces the following; all other inputs are ignored during reset.
  - s=0, lane register=0, o=0, o_valid=0, locked=0, sync_err=0, ovf=0.
  - Reset mid-frame discards any partial word and any pending word.
- Unlocked:
  - Beats without frame_start are dropped; s stays 0.
  - A beat with frame_start sets locked=1, writes lane[0]=din and sets s=1.
- Locked beat, no frame_start: lane[s]=din.
  - If s<WIDTH-1: s increments.
  - If s=WIDTH-1: the word completes and s wraps to 0.
- Locked beat with frame_start:
  - At s=0: this is a normal slot-0 beat. frame_start on every frame is allowed but not required.
  - At s≠0: the partial word is discarded (lanes 1..WIDTH-1 cleared), lane[0]=din, s=1, sync_err=1. No word is emitted.
- frame_start with din_valid=0 is ignored.
- Completion and latency:
  - On the edge of the slot-(WIDTH-1) beat, o is loaded with {din, lane[WIDTH-2:0]} and o_valid=1.
  - o and o_valid are therefore visible in the cycle after the last beat.
  - The lane register clears to 0.
- Output handshake:
  - o and o_valid hold steady while o_valid=1 and o_ready=0.
  - On accept (o_valid & o_ready) with no completion that edge: o_valid goes to 0 and o keeps its last value.
  - Accept and completion on the same edge: o loads the new word, o_valid stays 1, ovf is unchanged.
  - Completion while o_valid=1 and o_ready=0: o is overwritten with the new word, o_valid stays 1, ovf=1.
- Sticky flags:
  - err_clr=1 clears sync_err and ovf.
  - If err_clr and a new error occur on the same edge, the set wins.
- Timing:
  - Back-to-back beats (din_valid high every cycle) are supported at full rate: one word every WIDTH cycles.
  - Gaps in din_valid stall s without error.
- s output: always equals the internal slot counter. The transmitter may compare it to its own select for debug.

Test Plan:
- Basic frame: reset, then beats with frame_start on the first beat; din=1,0,1,1 for slots 0..3 and o_ready=1. Required: o=4'b1101 and o_valid=1 for exactly one cycle after beat 4; s sequence 1,2,3,0; locked=1.
- Pre-lock discard: 3 beats without frame_start, then a frame with din=0,1,1,0 and frame_start on the first beat. Required: the 3 early beats are ignored; o=4'b0110.
- Backpressure and overflow: o_ready=0 and two frames, 4'hA then 4'h5. Required:
  - o=4'hA held until the 2nd frame completes, then o=4'h5 with o_valid still 1 and ovf=1.
  - Raising o_ready clears o_valid on the next edge.
  - err_clr clears ovf.
- Resync: locked, beats for slots 0,1, then a frame_start beat. Required:
  - sync_err=1, no word emitted, s=1.
  - The next 3 beats (din=1,1,1, after a first bit 0) give o=4'b1110.
- Simultaneous accept and completion: o_valid=1 with o=4'h3 and o_ready=1 on the edge where the slot-3 beat of a 4'hC frame lands. Required: o=4'hC, o_valid stays 1, ovf=0.
- Reset mid-operation: assert rst_n=0 after slot 2 of a frame and while o_valid=1. Required:
  - Next cycle all outputs are 0 and locked=0.
  - Subsequent beats without frame_start produce nothing.
